// File: rtl/fp_pkg.sv
// Shared constants and FSM state encoding for the floating-point result packer.
package fp_pkg;

   localparam int EXP_W  = 8;
   localparam int MANT_W = 24;
   localparam int WORD_W = EXP_W + MANT_W;
   localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NORM = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/udCounter.sv
// Loadable up/down counter; load has priority over up, up over down.
module udCounter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_up,
   input  logic         i_down,
   output logic [W-1:0] o_q
);
   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] r_q;

   // Counter state update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_load_val;
      end else if (i_up) begin
         r_q <= r_q + ONE;
      end else if (i_down) begin
         r_q <= r_q - ONE;
      end else begin
         r_q <= r_q;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/fp_result_packer.sv
// Normalizes an adder result one bit per cycle and packs it into {sign, exp, fraction},
// resolving zero, overflow-to-infinity and underflow-flush cases.
module fp_result_packer #(
   parameter int EXP_W  = fp_pkg::EXP_W,
   parameter int MANT_W = fp_pkg::MANT_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_sign,
   input  logic [EXP_W-1:0]        in_exp,
   input  logic [MANT_W-1:0]       in_mant,
   input  logic                    in_co,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [EXP_W+MANT_W-1:0] out_word,
   output logic                    out_zero,
   output logic                    out_ovf,
   output logic                    out_unf
);
   import fp_pkg::*;

   localparam logic [EXP_W-1:0] EXP_ALL = {EXP_W{1'b1}};
   localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

   state_t                    r_state;
   state_t                    w_next_state;
   logic                      r_sign;
   logic [MANT_W:0]           r_mant;
   logic                      r_force_zero;
   logic                      r_force_inf;
   logic [EXP_W-1:0]          w_exp;
   logic                      w_mant_nz;
   logic                      w_capture;
   logic                      w_shift_r;
   logic                      w_shift_l;
   logic                      w_finish;
   logic [EXP_W-1:0]          w_res_exp;
   logic [MANT_W-2:0]         w_res_frac;
   logic                      w_res_zero;
   logic                      w_res_ovf;
   logic                      w_res_unf;
   logic                      r_valid;
   logic [EXP_W+MANT_W-1:0]   r_word;
   logic                      r_zero;
   logic                      r_ovf;
   logic                      r_unf;

   udCounter #(.W(EXP_W)) u_exp_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_capture),
      .i_load_val (in_exp),
      .i_up       (w_shift_r),
      .i_down     (w_shift_l),
      .o_q        (w_exp)
   );

   assign w_mant_nz = |r_mant;
   assign in_ready  = (r_state == ST_IDLE) & ~rst;

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state and per-edge normalization action; exactly one action per NORM cycle.
   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
      w_shift_r    = 1'b0;
      w_shift_l    = 1'b0;
      w_finish     = 1'b0;
      w_res_exp    = '0;
      w_res_frac   = '0;
      w_res_zero   = 1'b0;
      w_res_ovf    = 1'b0;
      w_res_unf    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (in_valid) begin
               w_capture    = 1'b1;
               w_next_state = ST_NORM;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_NORM: begin
            if (r_force_inf) begin
               w_finish  = 1'b1;
               w_res_exp = EXP_ALL;
               w_res_ovf = 1'b1;
            end else if (r_force_zero) begin
               w_finish   = 1'b1;
               w_res_unf  = w_mant_nz;
               w_res_zero = ~w_mant_nz;
            end else if (!w_mant_nz) begin
               w_finish   = 1'b1;
               w_res_zero = 1'b1;
            end else if (r_mant[MANT_W]) begin
               w_shift_r = 1'b1;
            end else if (!r_mant[MANT_W-1]) begin
               // Exponent 1 is the floor: further left shifts would denormalize, so flush.
               if (w_exp == EXP_ONE) begin
                  w_finish  = 1'b1;
                  w_res_unf = 1'b1;
               end else begin
                  w_shift_l = 1'b1;
               end
            end else if (w_exp == EXP_ALL) begin
               w_finish  = 1'b1;
               w_res_exp = EXP_ALL;
               w_res_ovf = 1'b1;
            end else begin
               w_finish   = 1'b1;
               w_res_exp  = w_exp;
               w_res_frac = r_mant[MANT_W-2:0];
            end
            if (w_finish) begin
               w_next_state = ST_DONE;
            end else begin
               w_next_state = ST_NORM;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_DONE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Working sign/mantissa and special-exponent markers captured at accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sign       <= 1'b0;
         r_mant       <= '0;
         r_force_zero <= 1'b0;
         r_force_inf  <= 1'b0;
      end else if (w_capture) begin
         r_sign       <= in_sign;
         r_mant       <= {in_co, in_mant};
         r_force_zero <= (in_exp == '0);
         r_force_inf  <= (in_exp == EXP_ALL);
      end else if (w_shift_r) begin
         r_mant <= {1'b0, r_mant[MANT_W:1]};
      end else if (w_shift_l) begin
         r_mant <= {r_mant[MANT_W-1:0], 1'b0};
      end else begin
         r_mant <= r_mant;
      end
   end

   // Output word and flags, held stable until consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_word  <= '0;
         r_zero  <= 1'b0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else if (w_finish) begin
         r_valid <= 1'b1;
         r_word  <= {r_sign, w_res_exp, w_res_frac};
         r_zero  <= w_res_zero;
         r_ovf   <= w_res_ovf;
         r_unf   <= w_res_unf;
      end else if ((r_state == ST_DONE) && out_ready) begin
         r_valid <= 1'b0;
         r_zero  <= 1'b0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_valid <= r_valid;
      end
   end

   assign out_valid = r_valid;
   assign out_word  = r_word;
   assign out_zero  = r_zero;
   assign out_ovf   = r_ovf;
   assign out_unf   = r_unf;

endmodule

// File: tb/tb_fp_result_packer.sv
// Directed and random checks of fp_result_packer against a value-level reference model.
module tb_fp_result_packer;

   localparam int WW = fp_pkg::WORD_W;
   localparam int EMAX = int'(fp_pkg::EXP_MAX);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic          in_sign;
   logic [7:0]    in_exp;
   logic [23:0]   in_mant;
   logic          in_co;
   logic          out_valid;
   logic          out_ready;
   logic [WW-1:0] out_word;
   logic          out_zero;
   logic          out_ovf;
   logic          out_unf;

   int checks = 0;
   int errors = 0;

   fp_result_packer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_exp    (in_exp),
      .in_mant   (in_mant),
      .in_co     (in_co),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .out_zero  (out_zero),
      .out_ovf   (out_ovf),
      .out_unf   (out_unf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Value-level model: normalize the integer mantissa by counting shifts, then classify.
   task automatic model(input logic s, input int e, input logic co, input logic [23:0] m,
                        output logic [31:0] w, output logic [2:0] flags, output int lat);
      logic [63:0] mm;
      logic [63:0] nv;
      int          ee;
      int          n;
      mm    = {39'd0, co, m};
      flags = 3'b000;
      w     = {s, 31'd0};
      if (e == 0) begin
         lat   = 1;
         flags = (mm != 64'd0) ? 3'b001 : 3'b100;
      end else if (e == EMAX) begin
         lat   = 1;
         w     = {s, 8'hFF, 23'd0};
         flags = 3'b010;
      end else if (mm == 64'd0) begin
         lat   = 1;
         flags = 3'b100;
      end else if (mm >= (64'd1 << 24)) begin
         lat = 2;
         ee  = e + 1;
         nv  = mm / 64'd2;
         if (ee == EMAX) begin
            w     = {s, 8'hFF, 23'd0};
            flags = 3'b010;
         end else begin
            w = {s, 8'(ee), nv[22:0]};
         end
      end else begin
         n = 0;
         while ((mm << n) < (64'd1 << 23)) n++;
         if (e - n >= 1) begin
            nv  = mm << n;
            w   = {s, 8'(e - n), nv[22:0]};
            lat = n + 1;
         end else begin
            lat   = e;
            flags = 3'b001;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                         input logic [23:0] m, input logic co, input int hold,
                         output logic [31:0] obs_word, output int obs_lat);
      logic [31:0] w;
      logic [2:0]  fl;
      int          lat;
      model(s, int'(e), co, m, w, fl, lat);
      chk({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_sign  = s;
      in_exp   = e;
      in_mant  = m;
      in_co    = co;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_mant  = 24'($urandom);
      obs_lat  = 0;
      while (!out_valid && obs_lat < 60) begin
         @(posedge clk); #1;
         obs_lat++;
      end
      obs_word = out_word;
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_latency"}, 64'(obs_lat), 64'(lat));
      chk({tag, "_word"}, 64'(out_word), 64'(w));
      chk({tag, "_flags"}, 64'({out_zero, out_ovf, out_unf}), 64'(fl));
      chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, "_hold_word"}, 64'(out_word), 64'(w));
         chk({tag, "_hold_flags"}, 64'({out_valid, out_zero, out_ovf, out_unf}), 64'({1'b1, fl}));
         chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_consumed"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      logic [31:0] ow;
      int          ol;
      int          saw;
      logic [7:0]  re;
      logic [23:0] rm;
      int          sel;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = 8'd0;
      in_mant   = 24'd0;
      in_co     = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("reset_valid", 64'(out_valid), 64'd0);
      chk("reset_word", 64'(out_word), 64'd0);
      chk("reset_flags", 64'({out_zero, out_ovf, out_unf}), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("release_in_ready", 64'(in_ready), 64'd1);

      run_op("d_norm", 1'b0, 8'h80, 24'hC00000, 1'b0, 0, ow, ol);
      chk("d_norm_word_const", 64'(ow), 64'h40400000);
      chk("d_norm_lat_const", 64'(ol), 64'd1);
      run_op("d_carry", 1'b0, 8'h7F, 24'h000000, 1'b1, 0, ow, ol);
      chk("d_carry_word_const", 64'(ow), 64'h40000000);
      chk("d_carry_lat_const", 64'(ol), 64'd2);
      run_op("d_left23", 1'b0, 8'h85, 24'h000001, 1'b0, 0, ow, ol);
      chk("d_left23_word_const", 64'(ow), 64'h37000000);
      chk("d_left23_lat_const", 64'(ol), 64'd24);
      run_op("d_zero", 1'b1, 8'h85, 24'h000000, 1'b0, 0, ow, ol);
      chk("d_zero_word_const", 64'(ow), 64'h80000000);
      chk("d_zero_flag_const", 64'(out_zero), 64'd0);
      run_op("d_ovf", 1'b0, 8'hFE, 24'h123456, 1'b1, 5, ow, ol);
      chk("d_ovf_word_const", 64'(ow), 64'h7F800000);
      run_op("d_unf", 1'b0, 8'h01, 24'h400000, 1'b0, 0, ow, ol);
      chk("d_unf_word_const", 64'(ow), 64'h00000000);
      run_op("d_exp0", 1'b1, 8'h00, 24'h800001, 1'b0, 0, ow, ol);
      run_op("d_expff", 1'b1, 8'hFF, 24'h000000, 1'b0, 0, ow, ol);
      run_op("d_flush2", 1'b0, 8'h02, 24'h200000, 1'b0, 0, ow, ol);

      in_valid = 1'b1;
      in_sign  = 1'b0;
      in_exp   = 8'h85;
      in_mant  = 24'h000001;
      in_co    = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("midrst_release_in_ready", 64'(in_ready), 64'd1);
      saw = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (out_valid) saw++;
      end
      chk("midrst_no_output", 64'(saw), 64'd0);

      for (int k = 0; k < 40; k++) begin
         sel = int'($urandom_range(0, 7));
         case (sel)
            0: re = 8'h00;
            1: re = 8'hFF;
            2: re = 8'hFE;
            3: re = 8'h01;
            4: re = 8'($urandom_range(1, 30));
            default: re = 8'($urandom);
         endcase
         rm = 24'($urandom) >> $urandom_range(0, 24);
         run_op("rnd", 1'($urandom), re, rm, ($urandom_range(0, 3) == 0), 0, ow, ol);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
